// File: rtl/instqueue.sv
// Instruction queue between fetch and decode: circular FIFO of (inst, pc) pairs
// with a one-cycle push-to-present latency and a whole-queue flush.
module instqueue #(
  parameter int IQ_DEPTH     = 16,
  parameter int IDWidth      = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_full_out,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out,
  input  logic                    decoder_instqueue_stall_in,
  input  logic                    decoder_instqueue_rst_in,
  input  logic                    rob_instqueue_rst_in
);

  localparam int PtrW = $clog2(IQ_DEPTH);
  localparam int CntW = PtrW + 1;

  logic [PtrW-1:0]         head_r;
  logic [PtrW-1:0]         tail_r;
  logic [CntW-1:0]         count_r;
  logic [IDWidth-1:0]      inst_mem_r [IQ_DEPTH];
  logic [AddressWidth-1:0] pc_mem_r   [IQ_DEPTH];

  logic flush_s;
  logic full_s;
  logic valid_s;
  logic push_s;
  logic pop_s;

  // Handshake decode; a full queue rejects pushes even when the head pops this cycle.
  always_comb begin
    flush_s = decoder_instqueue_rst_in | rob_instqueue_rst_in;
    full_s  = (count_r == CntW'(IQ_DEPTH));
    valid_s = (count_r != {CntW{1'b0}});
    push_s  = rdy_in & if_instqueue_en_in & ~full_s & ~flush_s;
    pop_s   = rdy_in & valid_s & ~decoder_instqueue_stall_in & ~flush_s;
  end

  // Pointer and occupancy state; flush wins over push and pop.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_r  <= {PtrW{1'b0}};
      tail_r  <= {PtrW{1'b0}};
      count_r <= {CntW{1'b0}};
    end else if (rdy_in) begin
      if (flush_s) begin
        head_r  <= {PtrW{1'b0}};
        tail_r  <= {PtrW{1'b0}};
        count_r <= {CntW{1'b0}};
      end else begin
        if (push_s) begin
          tail_r <= tail_r + PtrW'(1);
        end else begin
          tail_r <= tail_r;
        end
        if (pop_s) begin
          head_r <= head_r + PtrW'(1);
        end else begin
          head_r <= head_r;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CntW'(1);
          2'b01:   count_r <= count_r - CntW'(1);
          default: count_r <= count_r;
        endcase
      end
    end else begin
      head_r  <= head_r;
      tail_r  <= tail_r;
      count_r <= count_r;
    end
  end

  // Entry storage is never reset; an entry is only observable once count covers it.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      inst_mem_r[tail_r] <= if_instqueue_inst_in;
      pc_mem_r[tail_r]   <= if_instqueue_pc_in;
    end
  end

  // Decoder-facing view of the head, forced to zero when empty.
  always_comb begin
    instqueue_if_full_out    = full_s;
    instqueue_decoder_en_out = valid_s;
    if (valid_s) begin
      instqueue_decoder_inst_out = inst_mem_r[head_r];
      instqueue_decoder_pc_out   = pc_mem_r[head_r];
    end else begin
      instqueue_decoder_inst_out = {IDWidth{1'b0}};
      instqueue_decoder_pc_out   = {AddressWidth{1'b0}};
    end
  end

endmodule

// File: tb/tb_instqueue.sv
// Directed-vector bench for instqueue: push/pop, full, flush, stall-by-rdy and reset cases.
module tb_instqueue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        push_en;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic        full;
  logic        en;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        stall;
  logic        dec_rst;
  logic        rob_rst;

  int n_vec = 0;
  int n_err = 0;

  instqueue #(.IQ_DEPTH(16), .IDWidth(32), .AddressWidth(32)) dut (
    .clk_in                     (clk),
    .rst_n_in                   (rst_n),
    .rdy_in                     (rdy),
    .if_instqueue_en_in         (push_en),
    .if_instqueue_inst_in       (push_inst),
    .if_instqueue_pc_in         (push_pc),
    .instqueue_if_full_out      (full),
    .instqueue_decoder_en_out   (en),
    .instqueue_decoder_inst_out (inst_out),
    .instqueue_decoder_pc_out   (pc_out),
    .decoder_instqueue_stall_in (stall),
    .decoder_instqueue_rst_in   (dec_rst),
    .rob_instqueue_rst_in       (rob_rst)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; push_en = 1'b0; push_inst = 32'h0; push_pc = 32'h0;
    stall = 1'b0; dec_rst = 1'b0; rob_rst = 1'b0;
    step();
    step();
    check_val("rst_en", {31'h0, en}, 32'h0);
    check_val("rst_full", {31'h0, full}, 32'h0);
    check_val("rst_inst", inst_out, 32'h0);
    check_val("rst_pc", pc_out, 32'h0);
    rst_n = 1'b1;
    step();

    // Single push, then consumed with stall low.
    push_en = 1'b1; push_inst = 32'h0000_0013; push_pc = 32'h1000;
    step();
    push_en = 1'b0;
    check_val("one_en", {31'h0, en}, 32'h1);
    check_val("one_inst", inst_out, 32'h0000_0013);
    check_val("one_pc", pc_out, 32'h1000);
    step();
    check_val("one_gone_en", {31'h0, en}, 32'h0);
    check_val("one_gone_inst", inst_out, 32'h0);

    // Fill to 16 with stall high; pointers wrap since head starts at 1.
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_en = 1'b1; push_inst = 32'hA000 + i; push_pc = 32'h1000 + 4 * i;
      step();
      if (i == 14) check_val("fill15_full", {31'h0, full}, 32'h0);
    end
    check_val("fill_full", {31'h0, full}, 32'h1);
    check_val("fill_head", pc_out, 32'h1000);
    push_inst = 32'hA010; push_pc = 32'h1040;
    step();
    check_val("drop17_full", {31'h0, full}, 32'h1);
    check_val("drop17_head", pc_out, 32'h1000);

    // Full with simultaneous push and pop: push dropped, head advances.
    push_inst = 32'hBEEF; push_pc = 32'h1050; stall = 1'b0;
    step();
    push_en = 1'b0;
    check_val("fullpp_full", {31'h0, full}, 32'h0);
    check_val("fullpp_pc", pc_out, 32'h1004);
    for (int k = 0; k < 15; k++) begin
      check_val("drain_pc", pc_out, 32'h1004 + 4 * k);
      check_val("drain_inst", inst_out, 32'hA001 + k);
      step();
    end
    check_val("drain_empty", {31'h0, en}, 32'h0);

    // Flush from decoder with a concurrent push.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_en = 1'b1; push_inst = 32'h20 + i; push_pc = 32'h2000 + 4 * i;
      step();
    end
    check_val("pre_flush_pc", pc_out, 32'h2000);
    dec_rst = 1'b1; push_inst = 32'h30; push_pc = 32'h3000;
    step();
    dec_rst = 1'b0; push_en = 1'b0;
    check_val("flush_en", {31'h0, en}, 32'h0);
    check_val("flush_pc", pc_out, 32'h0);
    push_en = 1'b1; push_inst = 32'h55; push_pc = 32'h3100;
    step();
    push_en = 1'b0;
    check_val("post_flush_pc", pc_out, 32'h3100);
    check_val("post_flush_inst", inst_out, 32'h55);
    stall = 1'b0;
    step();
    check_val("post_flush_alone", {31'h0, en}, 32'h0);

    // Flush from commit stage.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_en = 1'b1; push_inst = 32'h70 + i; push_pc = 32'h7000 + 4 * i;
      step();
    end
    push_en = 1'b0; rob_rst = 1'b1;
    step();
    rob_rst = 1'b0;
    check_val("rob_flush_en", {31'h0, en}, 32'h0);

    // rdy low holds everything, including a flush request.
    for (int i = 0; i < 2; i++) begin
      push_en = 1'b1; push_inst = 32'h40 + i; push_pc = 32'h4000 + 4 * i;
      step();
    end
    rdy = 1'b0; push_inst = 32'h99; push_pc = 32'h4100; stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dec_rst = (c == 2);
      step();
      check_val("hold_en", {31'h0, en}, 32'h1);
      check_val("hold_pc", pc_out, 32'h4000);
    end
    rdy = 1'b1; push_en = 1'b0; dec_rst = 1'b0;
    check_val("resume_pc0", pc_out, 32'h4000);
    step();
    check_val("resume_pc1", pc_out, 32'h4004);
    check_val("resume_inst1", inst_out, 32'h41);
    step();
    check_val("resume_empty", {31'h0, en}, 32'h0);

    // Asynchronous reset pulse between edges with 3 entries held.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_en = 1'b1; push_inst = 32'h60 + i; push_pc = 32'h5000 + 4 * i;
      step();
    end
    push_en = 1'b0;
    check_val("pre_arst_en", {31'h0, en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_en", {31'h0, en}, 32'h0);
    check_val("arst_pc", pc_out, 32'h0);
    #1 rst_n = 1'b1;
    step();
    check_val("post_arst_en", {31'h0, en}, 32'h0);
    check_val("post_arst_full", {31'h0, full}, 32'h0);
    push_en = 1'b1; push_inst = 32'h66; push_pc = 32'h6000;
    step();
    push_en = 1'b0; stall = 1'b0;
    check_val("post_arst_push", pc_out, 32'h6000);
    step();
    check_val("post_arst_pop", {31'h0, en}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
